// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: FSM state codes
// and the bit-counter width derivation.
package sipo_deserializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_deserializer_bit_counter.sv
// Counts bits accepted into the current word; o_term flags that the next
// accepted bit completes the word.
module sipo_deserializer_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_term
);

  logic [CNT_W-1:0] r_cnt;

  // Bit count register: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer: assembles WIDTH-bit words MSB-first
// from a gated bit stream and hands them off with valid/ready.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  // Only the WIDTH-1 most recent bits need storing; the newest comes from din.
  localparam int SH_W = (WIDTH > 1) ? WIDTH - 1 : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [SH_W-1:0]  r_shreg;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overrun;
  logic [WIDTH-1:0] w_shreg_next;
  logic             w_shift;
  logic             w_load;
  logic             w_drop_valid;
  logic             w_overrun;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_cnt_term;

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shreg_next = din;
    end else begin : g_wn
      assign w_shreg_next = {r_shreg, din};
    end
  endgenerate

  sipo_deserializer_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_cnt  (bit_cnt),
    .o_term (w_cnt_term)
  );

  // Next-state and datapath control decode.
  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_load       = 1'b0;
    w_drop_valid = 1'b0;
    w_overrun    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      S_IDLE, S_SHIFT: begin
        if (din_valid) begin
          w_shift = 1'b1;
          if (w_cnt_term) begin
            w_load       = 1'b1;
            w_cnt_clr    = 1'b1;
            w_state_next = S_HOLD;
          end else begin
            w_cnt_inc    = 1'b1;
            w_state_next = S_SHIFT;
          end
        end else begin
          w_state_next = r_state;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          // Handoff; a same-cycle bit starts the next word (or fills it when WIDTH=1).
          if (din_valid) begin
            w_shift = 1'b1;
            if (w_cnt_term) begin
              w_load       = 1'b1;
              w_cnt_clr    = 1'b1;
              w_state_next = S_HOLD;
            end else begin
              w_cnt_inc    = 1'b1;
              w_drop_valid = 1'b1;
              w_state_next = S_SHIFT;
            end
          end else begin
            w_drop_valid = 1'b1;
            w_state_next = S_IDLE;
          end
        end else if (din_valid) begin
          w_overrun = 1'b1;
        end else begin
          w_overrun = 1'b0;
        end
      end
      default: begin
        w_cnt_clr    = 1'b1;
        w_drop_valid = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_overrun <= w_overrun;
      if (w_shift) begin
        r_shreg <= w_shreg_next[SH_W-1:0];
      end else begin
        r_shreg <= r_shreg;
      end
      if (w_load) begin
        r_out_data  <= w_shreg_next;
        r_out_valid <= 1'b1;
      end else if (w_drop_valid) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: directed scenarios then random
// traffic, checked against a bit-queue reference model.
module tb_sipo_deserializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  typedef struct {
    logic          valid;
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
    logic          ovr;
  } stat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          overrun;
  logic [CW-1:0] bit_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  int           m_bits[$];
  bit           m_hold = 1'b0;
  logic [W-1:0] m_data = '0;

  stat_t        q_stat[$];
  logic [W-1:0] q_word[$];
  int           q_pres[$];

  logic mon_prev_valid = 1'b0;
  logic mon_prev_hs    = 1'b0;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_add_bit(input logic b);
    m_bits.push_back(int'(b));
    if (m_bits.size() == W) begin
      for (int i = 0; i < W; i++) m_data[W-1-i] = m_bits[i][0];
      m_bits.delete();
      m_hold = 1'b1;
      q_word.push_back(m_data);
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, queue the expected status.
  task automatic drive(input logic r, input logic d, input logic v, input logic rdy);
    stat_t s;
    logic  ovr;
    rst = r; din = d; din_valid = v; out_ready = rdy;
    @(posedge clk);
    ovr = 1'b0;
    if (r) begin
      m_bits.delete();
      m_hold = 1'b0;
      m_data = '0;
    end else if (m_hold) begin
      if (rdy) begin
        m_hold = 1'b0;
        if (v) model_add_bit(d);
      end else if (v) begin
        ovr = 1'b1;
      end
    end else if (v) begin
      model_add_bit(d);
    end
    s.valid = m_hold;
    s.data  = m_data;
    s.cnt   = CW'(m_bits.size());
    s.ovr   = ovr;
    q_stat.push_back(s);
    #1;
  endtask

  task automatic feed_word(input logic [W-1:0] w, input logic rdy, input bit gapped);
    for (int i = W - 1; i >= 0; i--) begin
      drive(1'b0, w[i], 1'b1, rdy);
      if (gapped) drive(1'b0, 1'b0, 1'b0, rdy);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, rdy);
  endtask

  // Monitor: per-cycle status compare plus word-presentation scoreboard.
  always @(negedge clk) begin
    stat_t s;
    if (q_stat.size() > 0) begin
      s = q_stat.pop_front();
      check("out_valid", 32'(out_valid), 32'(s.valid));
      check("out_data",  32'(out_data),  32'(s.data));
      check("bit_cnt",   32'(bit_cnt),   32'(s.cnt));
      check("overrun",   32'(overrun),   32'(s.ovr));
      if (out_valid === 1'b1 && (!mon_prev_valid || mon_prev_hs)) begin
        q_pres.push_back(cyc);
        if (q_word.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL word_unexpected: got %0h, expected no word", out_data);
        end else begin
          check("word", 32'(out_data), 32'(q_word.pop_front()));
        end
      end
      mon_prev_valid = (out_valid === 1'b1);
      mon_prev_hs    = (out_valid === 1'b1) && (out_ready === 1'b1);
    end
  end

  initial begin
    // Reset with din_valid high
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);

    // Basic word, consumer not ready
    feed_word(8'hB2, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Gapped input
    feed_word(8'hB2, 1'b0, 1'b1);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Back-to-back with ready held
    q_pres.delete();
    feed_word(8'hA5, 1'b1, 1'b0);
    feed_word(8'h3C, 1'b1, 1'b0);
    idle(3, 1'b1);
    check("b2b_count", 32'(q_pres.size()), 32'd2);
    if (q_pres.size() == 2) check("b2b_spacing", 32'(q_pres[1] - q_pres[0]), 32'd8);

    // Overrun in HOLD
    feed_word(8'hB2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    feed_word(8'h5A, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Mid-word reset
    feed_word(8'h1F, 1'b0, 1'b0);
    idle(1, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    feed_word(8'hFF, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(299) == 0), 1'($urandom), ($urandom_range(9) < 7),
            ($urandom_range(1) == 1));
    end
    idle(W + 2, 1'b1);
    @(negedge clk);
    check("words_drained", 32'(q_word.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
